// File: rtl/biriscv_imem_arb_pkg.sv
// Shared definitions for the instruction-memory arbiter: FSM state encoding
// and the owner ids stored in the outstanding-read FIFO.
// Latency: n/a (package). Backpressure: n/a (package).
package biriscv_imem_arb_pkg;

    localparam logic [1:0] ARB   = 2'd0;
    localparam logic [1:0] LOCK  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;

    typedef enum logic [1:0] {
        S_ARB   = ARB,
        S_LOCK  = LOCK,
        S_DRAIN = DRAIN,
        S_FLUSH = FLUSH
    } arb_state_t;

    localparam logic OWNER_REQ0 = 1'b0;
    localparam logic OWNER_REQ1 = 1'b1;

endpackage

// File: rtl/biriscv_imem_arb_if.sv
// Bundle of the two requester ports and the icache port around the arbiter.
// Latency: n/a (wiring). Backpressure: carried by reqN_accept_o / icache_accept_i.
// Modports: slave = arbiter view, master = environment (requesters + icache).
interface biriscv_imem_arb_if;
    import biriscv_imem_arb_pkg::*;

    // requester 0 (frontend fetch)
    logic        req0_rd_i;
    logic [31:0] req0_pc_i;
    logic [1:0]  req0_priv_i;
    logic        req0_flush_i;
    logic        req0_invalidate_i;
    logic        req0_accept_o;
    logic        req0_valid_o;
    logic        req0_error_o;
    logic        req0_page_fault_o;
    logic [63:0] req0_inst_o;

    // requester 1 (secondary instruction-side master)
    logic        req1_rd_i;
    logic [31:0] req1_pc_i;
    logic [1:0]  req1_priv_i;
    logic        req1_accept_o;
    logic        req1_valid_o;
    logic        req1_error_o;
    logic        req1_page_fault_o;
    logic [63:0] req1_inst_o;

    // icache port
    logic        icache_rd_o;
    logic [31:0] icache_pc_o;
    logic [1:0]  icache_priv_o;
    logic        icache_flush_o;
    logic        icache_invalidate_o;
    logic        icache_accept_i;
    logic        icache_valid_i;
    logic        icache_error_i;
    logic        icache_page_fault_i;
    logic [63:0] icache_inst_i;

    modport slave (
        input  req0_rd_i, req0_pc_i, req0_priv_i, req0_flush_i, req0_invalidate_i,
        output req0_accept_o, req0_valid_o, req0_error_o, req0_page_fault_o, req0_inst_o,
        input  req1_rd_i, req1_pc_i, req1_priv_i,
        output req1_accept_o, req1_valid_o, req1_error_o, req1_page_fault_o, req1_inst_o,
        output icache_rd_o, icache_pc_o, icache_priv_o, icache_flush_o, icache_invalidate_o,
        input  icache_accept_i, icache_valid_i, icache_error_i, icache_page_fault_i, icache_inst_i
    );

    modport master (
        output req0_rd_i, req0_pc_i, req0_priv_i, req0_flush_i, req0_invalidate_i,
        input  req0_accept_o, req0_valid_o, req0_error_o, req0_page_fault_o, req0_inst_o,
        output req1_rd_i, req1_pc_i, req1_priv_i,
        input  req1_accept_o, req1_valid_o, req1_error_o, req1_page_fault_o, req1_inst_o,
        input  icache_rd_o, icache_pc_o, icache_priv_o, icache_flush_o, icache_invalidate_o,
        output icache_accept_i, icache_valid_i, icache_error_i, icache_page_fault_i, icache_inst_i
    );

endinterface

// File: rtl/biriscv_imem_arb_fifo.sv
// In-order owner FIFO (1 bit wide) recording which requester issued each read.
// Latency: head visible combinationally; push/pop take effect at the next edge.
// Backpressure: full_o; caller must not push when full unless popping the same cycle.
// Ports: clk_i/rst_i (sync, active-low), push_i/data_i, pop_i/data_o, full_o, empty_o, count_o.
module biriscv_imem_arb_fifo
    import biriscv_imem_arb_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int DEPTH_W = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             data_i,
    input  logic             pop_i,
    output logic             data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [DEPTH_W:0] count_o
);

    localparam logic [DEPTH_W:0] FULL_CNT = (DEPTH_W + 1)'(DEPTH);

    logic [DEPTH-1:0]   mem_q;
    logic [DEPTH_W-1:0] wr_ptr_q;
    logic [DEPTH_W-1:0] rd_ptr_q;
    logic [DEPTH_W:0]   count_q;

    // DEPTH is a power of two, so pointers wrap naturally. A push+pop at full
    // writes the slot being popped, which is safe because the head is read
    // combinationally before the edge.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/biriscv_imem_arb.sv
// Shares the icache read port between req0 (fetch) and req1, routes responses
// back in issue order and sequences flush/invalidate around in-flight reads.
// Latency: request and response paths are combinational (zero added cycles).
// Backpressure: reads held via LOCK until icache_accept_i; owner FIFO full blocks grants.
// Ports: clk_i, rst_i (sync, active-low), bus (biriscv_imem_arb_if.slave).
// Build option: BIRISCV_IMEM_ARB_RR_EN selects round-robin instead of fixed req0 priority.
module biriscv_imem_arb
    import biriscv_imem_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING   = 2,
    parameter int MAX_OUTSTANDING_W = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    biriscv_imem_arb_if.slave   bus
);

    arb_state_t state_q;
    logic       lock_owner_q;
    logic       pend_flush_q;
    logic       pend_inv_q;

    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       fifo_head;
    logic [MAX_OUTSTANDING_W:0] fifo_count;

    logic pend_any;
    logic can_issue;
    logic arb_owner;
    logic gnt_vld;
    logic gnt_owner;
    logic push;
    logic pop;
    logic rsp0;
    logic rsp1;

    assign pend_any  = pend_flush_q | pend_inv_q;
    // A response popping this cycle frees a slot for a read accepted this cycle.
    assign can_issue = !fifo_full || bus.icache_valid_i;

`ifdef BIRISCV_IMEM_ARB_RR_EN
    logic rr_q;

    // rr_q names the master preferred when both request.
    assign arb_owner = (bus.req0_rd_i && bus.req1_rd_i) ? rr_q :
                       (bus.req1_rd_i ? OWNER_REQ1 : OWNER_REQ0);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rr_q <= OWNER_REQ0;
        end else if (push) begin
            rr_q <= ~gnt_owner;
        end
    end
`else
    assign arb_owner = bus.req0_rd_i ? OWNER_REQ0 : OWNER_REQ1;
`endif

    always_comb begin
        gnt_vld   = 1'b0;
        gnt_owner = arb_owner;
        if (state_q == S_LOCK) begin
            gnt_vld   = 1'b1;
            gnt_owner = lock_owner_q;
        end else if (state_q == S_ARB && !pend_any && can_issue &&
                     (bus.req0_rd_i || bus.req1_rd_i)) begin
            gnt_vld = 1'b1;
        end
        if (!rst_i) begin
            gnt_vld = 1'b0;
        end
    end

    assign push = gnt_vld && bus.icache_accept_i;
    assign pop  = rst_i && bus.icache_valid_i && !fifo_empty;

    biriscv_imem_arb_fifo #(
        .DEPTH   (MAX_OUTSTANDING),
        .DEPTH_W (MAX_OUTSTANDING_W)
    ) u_owner_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (gnt_owner),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= S_ARB;
            lock_owner_q <= OWNER_REQ0;
            pend_flush_q <= 1'b0;
            pend_inv_q   <= 1'b0;
        end else begin
            case (state_q)
                S_ARB: begin
                    if (pend_any) begin
                        state_q <= S_DRAIN;
                    end else if (gnt_vld && !bus.icache_accept_i) begin
                        state_q      <= S_LOCK;
                        lock_owner_q <= gnt_owner;
                    end
                end
                S_LOCK: begin
                    if (bus.icache_accept_i) begin
                        state_q <= S_ARB;
                    end
                end
                S_DRAIN: begin
                    if (fifo_count == '0) begin
                        state_q <= S_FLUSH;
                    end
                end
                default: begin
                    state_q <= S_ARB;
                end
            endcase

            // Pulses accumulate until the single FLUSH cycle consumes them.
            if (state_q == S_FLUSH) begin
                pend_flush_q <= 1'b0;
                pend_inv_q   <= 1'b0;
            end else begin
                pend_flush_q <= pend_flush_q | bus.req0_flush_i;
                pend_inv_q   <= pend_inv_q   | bus.req0_invalidate_i;
            end
        end
    end

    // Request path
    assign bus.icache_rd_o   = gnt_vld;
    assign bus.icache_pc_o   = !gnt_vld ? 32'd0 :
                               (gnt_owner == OWNER_REQ1 ? bus.req1_pc_i : bus.req0_pc_i);
    assign bus.icache_priv_o = !gnt_vld ? 2'd0 :
                               (gnt_owner == OWNER_REQ1 ? bus.req1_priv_i : bus.req0_priv_i);
    assign bus.req0_accept_o = push && (gnt_owner == OWNER_REQ0);
    assign bus.req1_accept_o = push && (gnt_owner == OWNER_REQ1);

    assign bus.icache_flush_o      = rst_i && (state_q == S_FLUSH) && pend_flush_q;
    assign bus.icache_invalidate_o = rst_i && (state_q == S_FLUSH) && pend_inv_q;

    // Response path: only the FIFO head's owner sees the response.
    assign rsp0 = pop && (fifo_head == OWNER_REQ0);
    assign rsp1 = pop && (fifo_head == OWNER_REQ1);

    assign bus.req0_valid_o      = rsp0;
    assign bus.req0_error_o      = rsp0 && bus.icache_error_i;
    assign bus.req0_page_fault_o = rsp0 && bus.icache_page_fault_i;
    assign bus.req0_inst_o       = rsp0 ? bus.icache_inst_i : 64'd0;
    assign bus.req1_valid_o      = rsp1;
    assign bus.req1_error_o      = rsp1 && bus.icache_error_i;
    assign bus.req1_page_fault_o = rsp1 && bus.icache_page_fault_i;
    assign bus.req1_inst_o       = rsp1 ? bus.icache_inst_i : 64'd0;

endmodule

// File: tb/tb_biriscv_imem_arb.sv
// Self-checking bench for biriscv_imem_arb: directed scenarios then random traffic,
// every cycle compared against a queue-based reference model of the arbiter rules.
// Runs for either build of BIRISCV_IMEM_ARB_RR_EN.
module tb_biriscv_imem_arb;

    localparam int MAXO = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    biriscv_imem_arb_if bus ();

    biriscv_imem_arb #(
        .MAX_OUTSTANDING   (MAXO),
        .MAX_OUTSTANDING_W (1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: outstanding owners in issue order, the master currently
    // stuck waiting for accept, latched maintenance requests and phase.
    int m_q[$];
    int m_lock  = -1;
    bit m_wf    = 1'b0;
    bit m_wi    = 1'b0;
    int m_phase = 0;   // 0 normal, 1 waiting for reads to return, 2 maintenance cycle
    int m_rr    = 0;

    bit e_acc0, e_acc1;

    // snapshots of DUT outputs taken at the checking point of the last step
    logic        s_rd, s_acc0, s_acc1, s_v0, s_v1, s_fl;
    logic [31:0] s_pc;
    logic [63:0] s_inst0, s_inst1;

    task automatic chk(input string tag, input logic [99:0] obs, input logic [99:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        int          g;
        int          own;
        int          sz0;
        bit          lock0;
        logic [31:0] epc;
        logic [1:0]  epr;
        @(negedge clk);
        s_rd    = bus.icache_rd_o;
        s_pc    = bus.icache_pc_o;
        s_acc0  = bus.req0_accept_o;
        s_acc1  = bus.req1_accept_o;
        s_v0    = bus.req0_valid_o;
        s_v1    = bus.req1_valid_o;
        s_inst0 = bus.req0_inst_o;
        s_inst1 = bus.req1_inst_o;
        s_fl    = bus.icache_flush_o;
        if (!rst_n) begin
            e_acc0 = 1'b0;
            e_acc1 = 1'b0;
            chk("rst_icache", {bus.icache_rd_o, bus.icache_priv_o, bus.icache_pc_o,
                               bus.icache_flush_o, bus.icache_invalidate_o}, '0);
            chk("rst_accept", {bus.req1_accept_o, bus.req0_accept_o}, '0);
            chk("rst_rsp0", {bus.req0_valid_o, bus.req0_error_o, bus.req0_page_fault_o,
                             bus.req0_inst_o}, '0);
            chk("rst_rsp1", {bus.req1_valid_o, bus.req1_error_o, bus.req1_page_fault_o,
                             bus.req1_inst_o}, '0);
            m_q.delete();
            m_lock  = -1;
            m_wf    = 1'b0;
            m_wi    = 1'b0;
            m_phase = 0;
            m_rr    = 0;
        end else begin
            g = -1;
            if (m_lock >= 0) begin
                g = m_lock;
            end else if (m_phase == 0 && !(m_wf || m_wi) &&
                         (m_q.size() < MAXO || bus.icache_valid_i) &&
                         (bus.req0_rd_i || bus.req1_rd_i)) begin
`ifdef BIRISCV_IMEM_ARB_RR_EN
                if (bus.req0_rd_i && bus.req1_rd_i) g = m_rr;
                else g = bus.req0_rd_i ? 0 : 1;
`else
                g = bus.req0_rd_i ? 0 : 1;
`endif
            end
            epc = (g == 0) ? bus.req0_pc_i : (g == 1) ? bus.req1_pc_i : 32'd0;
            epr = (g == 0) ? bus.req0_priv_i : (g == 1) ? bus.req1_priv_i : 2'd0;
            e_acc0 = (g == 0) && bus.icache_accept_i;
            e_acc1 = (g == 1) && bus.icache_accept_i;
            own = (bus.icache_valid_i && m_q.size() > 0) ? m_q[0] : -1;

            chk("icache_req", {bus.icache_rd_o, bus.icache_priv_o, bus.icache_pc_o},
                {(g >= 0), epr, epc});
            chk("accept", {bus.req1_accept_o, bus.req0_accept_o}, {e_acc1, e_acc0});
            chk("rsp0", {bus.req0_valid_o, bus.req0_error_o, bus.req0_page_fault_o, bus.req0_inst_o},
                (own == 0) ? {1'b1, bus.icache_error_i, bus.icache_page_fault_i, bus.icache_inst_i}
                           : 67'd0);
            chk("rsp1", {bus.req1_valid_o, bus.req1_error_o, bus.req1_page_fault_o, bus.req1_inst_o},
                (own == 1) ? {1'b1, bus.icache_error_i, bus.icache_page_fault_i, bus.icache_inst_i}
                           : 67'd0);
            chk("flush_inv", {bus.icache_flush_o, bus.icache_invalidate_o},
                {(m_phase == 2) && m_wf, (m_phase == 2) && m_wi});

            sz0   = m_q.size();
            lock0 = (m_lock >= 0);
            if (own >= 0) void'(m_q.pop_front());
            if (g >= 0) begin
                if (bus.icache_accept_i) begin
                    m_q.push_back(g);
                    m_lock = -1;
                    m_rr   = 1 - g;
                end else begin
                    m_lock = g;
                end
            end
            if (m_phase == 2) begin
                m_wf    = 1'b0;
                m_wi    = 1'b0;
                m_phase = 0;
            end else begin
                if (m_phase == 1 && sz0 == 0) m_phase = 2;
                else if (m_phase == 0 && !lock0 && (m_wf || m_wi)) m_phase = 1;
                m_wf = m_wf | bus.req0_flush_i;
                m_wi = m_wi | bus.req0_invalidate_i;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_rd_i = 0; bus.req1_rd_i = 0;
        bus.req0_flush_i = 0; bus.req0_invalidate_i = 0;
        bus.icache_accept_i = 0; bus.icache_valid_i = 0;
        bus.icache_error_i = 0; bus.icache_page_fault_i = 0;
        bus.icache_inst_i = 64'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    bit act0, act1;

    initial begin
        bus.req0_pc_i = 32'h0000_1000; bus.req0_priv_i = 2'd3;
        bus.req1_pc_i = 32'h0000_2000; bus.req1_priv_i = 2'd1;
        idle_inputs();
        @(posedge clk);
        #1;

        // single fetch from req0, response two cycles later
        do_reset();
        bus.req0_rd_i = 1; bus.icache_accept_i = 1;
        step();
        chk("d1_accept0", s_acc0, 1'b1);
        chk("d1_pc", s_pc, 32'h0000_1000);
        bus.req0_rd_i = 0;
        step();
        bus.icache_valid_i = 1; bus.icache_inst_i = 64'hDEAD_BEEF_0000_0013;
        step();
        chk("d1_valid0", s_v0, 1'b1);
        chk("d1_inst0", s_inst0, 64'hDEAD_BEEF_0000_0013);
        chk("d1_valid1", s_v1, 1'b0);

        // both masters requesting, responses delayed
        do_reset();
        bus.req0_rd_i = 1; bus.req1_rd_i = 1; bus.icache_accept_i = 1;
        step();
        chk("d2_grant_a", {s_acc1, s_acc0}, 2'b01);
        step();
`ifdef BIRISCV_IMEM_ARB_RR_EN
        chk("d2_grant_b", {s_acc1, s_acc0}, 2'b10);
`else
        chk("d2_grant_b", {s_acc1, s_acc0}, 2'b01);
`endif
        step();
        chk("d2_full_blocks", s_rd, 1'b0);
        bus.req0_rd_i = 0; bus.req1_rd_i = 0;
        bus.icache_valid_i = 1; bus.icache_inst_i = 64'hAAAA_0000_0000_0001;
        step();
        chk("d2_route_a", {s_v1, s_v0, s_inst0}, {2'b01, 64'hAAAA_0000_0000_0001});
        bus.icache_inst_i = 64'hBBBB_0000_0000_0002;
        step();
`ifdef BIRISCV_IMEM_ARB_RR_EN
        chk("d2_route_b", {s_v1, s_v0, s_inst1}, {2'b10, 64'hBBBB_0000_0000_0002});
`else
        chk("d2_route_b", {s_v1, s_v0, s_inst0}, {2'b01, 64'hBBBB_0000_0000_0002});
`endif

        // icache stalls with req0 granted; req1 must wait
        do_reset();
        bus.req0_rd_i = 1;
        step();
        chk("d3_pc_c0", s_pc, 32'h0000_1000);
        bus.req1_rd_i = 1;
        step();
        chk("d3_pc_c1", s_pc, 32'h0000_1000);
        step();
        chk("d3_pc_c2", {s_pc, s_acc1}, {32'h0000_1000, 1'b0});
        bus.icache_accept_i = 1;
        step();
        chk("d3_accept0", {s_acc1, s_acc0, s_pc}, {2'b01, 32'h0000_1000});
        bus.req0_rd_i = 0;
        step();
        chk("d3_accept1", {s_acc1, s_acc0, s_pc}, {2'b10, 32'h0000_2000});

        // occupancy limit and push+pop at full
        do_reset();
        bus.req0_rd_i = 1; bus.icache_accept_i = 1;
        step();
        step();
        step();
        chk("d4_third_blocked", {s_rd, s_acc0}, 2'b00);
        bus.icache_valid_i = 1;
        step();
        chk("d4_swap", {s_acc0, s_v0}, 2'b11);
        bus.icache_valid_i = 0;
        step();
        chk("d4_still_full", s_rd, 1'b0);

        // flush with two outstanding
        do_reset();
        bus.req0_rd_i = 1; bus.icache_accept_i = 1;
        step();
        step();
        bus.req0_flush_i = 1;
        step();
        bus.req0_flush_i = 0;
        for (int i = 0; i < 4; i++) begin
            bus.icache_valid_i = (i == 1 || i == 3);
            step();
            chk("d5_no_read", {s_rd, s_fl}, 2'b00);
        end
        bus.icache_valid_i = 0;
        step();
        chk("d5_pre_flush", {s_rd, s_fl}, 2'b00);
        step();
        chk("d5_flush", {s_rd, s_fl}, 2'b01);
        step();
        chk("d5_resume", {s_rd, s_fl}, 2'b10);

        // reset with one outstanding, then a stray response
        do_reset();
        bus.req0_rd_i = 1; bus.icache_accept_i = 1;
        step();
        rst_n = 1'b0;
        step();
        chk("d6_rst_quiet", {s_rd, s_acc0}, 2'b00);
        rst_n = 1'b1;
        bus.req0_rd_i = 0;
        bus.icache_valid_i = 1; bus.icache_inst_i = 64'h1234_5678_9ABC_DEF0;
        step();
        chk("d6_stray_drop", {s_v1, s_v0}, 2'b00);

        // random traffic against the model
        do_reset();
        act0 = 0; act1 = 0;
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            if (!act0 && $urandom_range(0, 2) == 0) begin
                act0 = 1;
                bus.req0_pc_i = $urandom() & 32'hFFFF_FFFC;
                bus.req0_priv_i = 2'($urandom_range(0, 3));
            end
            if (!act1 && $urandom_range(0, 2) == 0) begin
                act1 = 1;
                bus.req1_pc_i = $urandom() & 32'hFFFF_FFFC;
                bus.req1_priv_i = 2'($urandom_range(0, 3));
            end
            bus.req0_rd_i = act0;
            bus.req1_rd_i = act1;
            bus.icache_accept_i = ($urandom_range(0, 3) != 0);
            bus.icache_valid_i = (m_q.size() > 0) ? 1'($urandom_range(0, 1))
                                                  : ($urandom_range(0, 15) == 0);
            bus.icache_inst_i = {$urandom(), $urandom()};
            bus.icache_error_i = ($urandom_range(0, 7) == 0);
            bus.icache_page_fault_i = ($urandom_range(0, 7) == 0);
            bus.req0_flush_i = ($urandom_range(0, 30) == 0);
            bus.req0_invalidate_i = ($urandom_range(0, 30) == 0);
            step();
            if (e_acc0) act0 = 0;
            if (e_acc1) act1 = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
